// File: rtl/hazard_control.sv
// hazard_control
//   Pipeline hazard and stall controller that sits beside the decode stage.
//   It detects load-use hazards against the instruction in EX, flushes IF/ID
//   after a taken branch or jump resolved in EX, and freezes the whole
//   pipeline while data memory is not ready.
//
// Ports
//   clk          : single clock, rising edge
//   reset        : asynchronous, active-low reset
//   ID_rs/ID_rt  : source register fields of the instruction in ID
//   ID_UsesRt    : ID instruction reads rt
//   EX_MemRead   : EX instruction is a load
//   EX_WriteReg  : destination register of the EX instruction
//   EX_Redirect  : taken branch / jump resolved in EX
//   mem_ready    : data memory ready, 0 freezes the pipeline
//   PC_enable, IFID_enable, IDEX_enable : pipeline write enables
//   IFID_flush   : IF/ID clears to a NOP
//   IDEX_bubble  : zero all ID/EX control inputs
//   state        : FSM state for debug (0 RUN, 1 LSTALL, 2 FLUSH)
//   stall_cycles : saturating count of cycles with PC_enable = 0
//   redirects    : saturating count of accepted redirects
//
// Handshake note: there is no valid/ready pair here. Every output is a
// Mealy function of the registered state/counter and the current inputs,
// valid in the same cycle the inputs are presented.
module hazard_control #(
    parameter int unsigned LOAD_LAT     = 1,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ID_rs,
    input  logic [4:0]       ID_rt,
    input  logic             ID_UsesRt,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_WriteReg,
    input  logic             EX_Redirect,
    input  logic             mem_ready,
    output logic             PC_enable,
    output logic             IFID_enable,
    output logic             IFID_flush,
    output logic             IDEX_enable,
    output logic             IDEX_bubble,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] redirects
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_LSTALL = 2'd1,
        ST_FLUSH  = 2'd2
    } state_t;

    // Remaining-cycle reload values; the first cycle of a window is spent in
    // RUN, so the extra state only covers the rest.
    localparam logic [3:0] LOAD_RELOAD  = 4'(LOAD_LAT - 1);
    localparam logic [3:0] FLUSH_RELOAD = 4'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] redirects_q, redirects_d;

    logic load_use;
    logic pc_en, ifid_en, ifid_fl, idex_en, idex_bub;
    logic redirect_acc;

    // Register $0 is never a real dependency.
    assign load_use = EX_MemRead && (EX_WriteReg != 5'd0) &&
                      ((EX_WriteReg == ID_rs) ||
                       (ID_UsesRt && (EX_WriteReg == ID_rt)));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pc_en        = 1'b0;
        ifid_en      = 1'b0;
        ifid_fl      = 1'b0;
        idex_en      = 1'b0;
        idex_bub     = 1'b0;
        redirect_acc = 1'b0;

        // Gating with reset keeps every enable low while reset is held,
        // independent of the registered state. A frozen cycle leaves all
        // outputs low and holds state and cnt.
        if (reset && mem_ready) begin
            case (state_q)
                ST_RUN: begin
                    if (EX_Redirect) begin
                        // Redirect wins over a simultaneous load-use.
                        pc_en        = 1'b1;
                        ifid_en      = 1'b1;
                        ifid_fl      = 1'b1;
                        idex_en      = 1'b1;
                        idex_bub     = 1'b1;
                        redirect_acc = 1'b1;
                        if (FLUSH_CYCLES > 1) begin
                            state_d = ST_FLUSH;
                            cnt_d   = FLUSH_RELOAD;
                        end
                    end else if (load_use) begin
                        idex_en  = 1'b1;
                        idex_bub = 1'b1;
                        if (LOAD_LAT > 1) begin
                            state_d = ST_LSTALL;
                            cnt_d   = LOAD_RELOAD;
                        end
                    end else begin
                        pc_en   = 1'b1;
                        ifid_en = 1'b1;
                        idex_en = 1'b1;
                    end
                end
                ST_LSTALL: begin
                    // EX holds a bubble here, so redirect/load_use are moot.
                    idex_en  = 1'b1;
                    idex_bub = 1'b1;
                    cnt_d    = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    pc_en    = 1'b1;
                    ifid_en  = 1'b1;
                    ifid_fl  = 1'b1;
                    idex_en  = 1'b1;
                    idex_bub = 1'b1;
                    if (EX_Redirect) begin
                        // This cycle is the new redirect's first flush cycle.
                        redirect_acc = 1'b1;
                        cnt_d        = FLUSH_RELOAD;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                        if (cnt_q == 4'd1) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                end
            endcase
        end

        stall_cycles_d = stall_cycles_q;
        if (!pc_en && (stall_cycles_q != '1)) begin
            stall_cycles_d = stall_cycles_q + CNT_ONE;
        end

        redirects_d = redirects_q;
        if (redirect_acc && (redirects_q != '1)) begin
            redirects_d = redirects_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_RUN;
            cnt_q          <= 4'd0;
            stall_cycles_q <= '0;
            redirects_q    <= '0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            stall_cycles_q <= stall_cycles_d;
            redirects_q    <= redirects_d;
        end
    end

    assign PC_enable    = pc_en;
    assign IFID_enable  = ifid_en;
    assign IFID_flush   = ifid_fl;
    assign IDEX_enable  = idex_en;
    assign IDEX_bubble  = idex_bub;
    assign state        = state_q;
    assign stall_cycles = stall_cycles_q;
    assign redirects    = redirects_q;

endmodule
